// File: rtl/cla_multiword_add_seq.sv
// rtl/cla_multiword_add_seq.sv - word-serial wide add/sub sequencer around a shared 16-bit CLA

// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level across groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  // Bit propagate/generate, group P/G, group carries, then carries inside each group.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    c  = '0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
    gc[0] = c0;
    gc[1] = gg[0] | (gp[0] & c0);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c0);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    s    = p ^ c;
    cout = gc[4];
  end

endmodule

// Sequencer: latches a request, feeds one 16-bit word per cycle (LSW first) through cla16,
// ripples the carry through a register and holds the result until the consumer takes it.
module cla_multiword_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NWORDS-1:0] op_a,
  input  logic [16*NWORDS-1:0] op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NWORDS-1:0] result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 busy
);

  localparam int W  = 16 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result_r;
  logic [IW-1:0] idx;
  logic          carry_r;
  logic          carry_out_r;
  logic          overflow_r;
  logic [15:0]   a_word;
  logic [15:0]   b_word;
  logic [15:0]   s_word;
  logic          c_word;

  // Select the operand words addressed by the current word index.
  always_comb begin
    a_word = a_reg[{idx, 4'b0000} +: 16];
    b_word = b_reg[{idx, 4'b0000} +: 16];
  end

  cla16 u_cla (
    .a    (a_word),
    .b    (b_word),
    .c0   (carry_r),
    .s    (s_word),
    .cout (c_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and status outputs; status is decoded from state so reset clears it at once.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on handshake, one word per RUN cycle, flags on the last word.
  // Subtraction is folded in at capture: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      result_r    <= '0;
      idx         <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            carry_r <= sub;
            idx     <= '0;
          end
        end
        RUN: begin
          result_r[{idx, 4'b0000} +: 16] <= s_word;
          carry_r <= c_word;
          idx     <= idx + 1'b1;
          if (idx == LAST) begin
            carry_out_r <= c_word;
            overflow_r  <= (a_word[15] == b_word[15]) & (s_word[15] != a_word[15]);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// tb/tb_cla_multiword_add_seq.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_cla_multiword_add_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int applied = 0;
  int miscompares = 0;

  cla_multiword_add_seq #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic; overflow from the exact signed result, carry as no-borrow for sub.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic signed [W+1:0] sa, sb, sr;
    logic [W:0] usum;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    sr = s ? (sa - sb) : (sa + sb);
    v  = !((sr[W+1] == sr[W]) && (sr[W] == sr[W-1]));
    usum = {1'b0, a} + {1'b0, b};
    r  = s ? (a - b) : (a + b);
    c  = s ? (a >= b) : usum[W];
  endtask

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] x;
    for (int i = 0; i < NW; i++) x[16*i +: 16] = rnd_word();
    return x;
  endfunction

  // One full transaction; bp = cycles of out_ready low in DONE, with a stray request offered meanwhile.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int bp,
                        input string tag, output logic [W-1:0] r, output logic c, output logic v,
                        output int lat);
    logic [W-1:0] r0;
    logic [2:0]   f0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = rnd_op(); op_b = rnd_op(); sub = ~s;
    lat = 1;
    while (!out_valid && lat <= 40) begin
      chk({tag, "_run_busy_inready"}, {busy, in_ready}, 2'b10);
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      chk({tag, "_out_valid_timeout"}, 0, 1);
    end
    r = result; c = carry_out; v = overflow;
    r0 = result; f0 = {carry_out, overflow, busy};
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = rnd_op(); op_b = rnd_op();
      @(posedge clk); #1;
      chk({tag, "_bp_result"}, result, r0);
      chk({tag, "_bp_flags"}, {out_valid, in_ready, f0}, {1'b1, 1'b0, carry_out, overflow, busy});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_return_idle"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  logic [W-1:0] r, er;
  logic         c, ec, v, ev;
  int           lat;
  bit           seen;

  initial begin
    tbl[0] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[7] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", {out_valid, in_ready, busy}, 3'b010);
    chk("reset_result", result, 0);
    chk("reset_flags", {carry_out, overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, $sformatf("vec%0d", i), r, c, v, lat);
      chk($sformatf("vec%0d_result", i), r, tbl[i].r);
      chk($sformatf("vec%0d_carry", i), c, tbl[i].c);
      chk($sformatf("vec%0d_overflow", i), v, tbl[i].v);
      chk($sformatf("vec%0d_latency", i), lat, NW + 1);
    end

    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 10, "bp", r, c, v, lat);
    chk("bp_result_final", r, 64'h2222_2222_2222_2211);
    chk("bp_carry_final", c, 0);

    @(negedge clk);
    op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0202_0303_0404; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_status", {out_valid, in_ready, busy}, 3'b010);
    chk("midrun_reset_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrun_no_out_valid", seen, 0);
    run_op(64'h1, 64'h2, 1'b0, 0, "post_reset", r, c, v, lat);
    chk("post_reset_result", r, 64'h3);

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b;
      logic s;
      a = rnd_op(); b = rnd_op(); s = 1'($urandom);
      model(a, b, s, er, ec, ev);
      run_op(a, b, s, $urandom_range(0, 2), "rnd", r, c, v, lat);
      chk($sformatf("rnd%0d_result", n), r, er);
      chk($sformatf("rnd%0d_cv", n), {c, v}, {ec, ev});
      chk($sformatf("rnd%0d_latency", n), lat, NW + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
